fake_signal_sequencer: RTL
==========================

FAKE_SIGNAL_SEQUENCER -- requirements
Module: fake_signal_sequencer

Interface
REQ-001 Parameter NSTEPS, default 8, number of program table entries (power of 2, 2..16).
REQ-002 Parameter DWELL_BITS, default 25, width of per-step dwell counter in CLK cycles.
REQ-003 Parameter CLEAR_CYCLES, default 4, cycles the generator is held in MODE=0 before each step.
REQ-004 Port CLK  input  1  system clock; all logic on posedge CLK.
REQ-005 Port RESET  input  1  synchronous, active-high reset.
REQ-006 Port START  input  1  single-cycle request to run the programmed sequence.
REQ-007 Port ABORT  input  1  single-cycle request to stop the sequence.
REQ-008 Port LOOP  input  1  repeat the sequence after the last step (only honoured when FAKE_SEQ_LOOP_EN is defined).
REQ-009 Port NUM_STEPS  input  $clog2(NSTEPS)+1  number of table entries to execute, sampled on accepted START.
REQ-010 Port CFG_WE  input  1  table write strobe.
REQ-011 Port CFG_ADDR  input  $clog2(NSTEPS)  table entry index.
REQ-012 Port CFG_DATA  input  32  entry: [31] shower enable, [30] muon enable, [29:25] MODE, [24:0] dwell.
REQ-013 Port MODE  output  5  MODE drive to the fake signal generator.
REQ-014 Port USE_FAKE_SHWR / USE_FAKE_MUON  output  1 each  generator enables.
REQ-015 Port BUSY  output  1  high in every state except IDLE.
REQ-016 Port DONE  output  1  one-cycle pulse on sequence completion or abort.
REQ-017 Port STEP_IDX  output  $clog2(NSTEPS)  index of the entry currently in RUN.

Function
REQ-018 States SHALL be IDLE, CLEAR, RUN; all outputs registered.
REQ-019 START in IDLE at cycle t SHALL enter CLEAR at t+1 with STEP_IDX=0; START while BUSY SHALL be ignored.
REQ-020 In CLEAR, MODE=0 and both enables=0 for exactly CLEAR_CYCLES cycles, then RUN.
REQ-021 In RUN, MODE/enables SHALL equal the current entry fields for exactly max(dwell,1) cycles.
REQ-022 At RUN end: if STEP_IDX+1 < NUM_STEPS, increment STEP_IDX and go CLEAR; else go CLEAR then IDLE (final clear so generator is left reset).
REQ-023 DONE SHALL pulse in the first IDLE cycle after the final CLEAR; BUSY falls in the same cycle.
REQ-024 NUM_STEPS=0 SHALL run one CLEAR then IDLE with DONE; NUM_STEPS>NSTEPS SHALL be clamped to NSTEPS.
REQ-025 ABORT in CLEAR or RUN SHALL force a fresh full CLEAR then IDLE with DONE; ABORT in IDLE ignored.
REQ-026 ABORT and START in the same cycle: ABORT wins; START is dropped.
REQ-027 CFG_WE while BUSY SHALL be ignored; in IDLE the entry is written on the same edge.
REQ-028 Dwell counter SHALL count down without wrap; dwell=2^DWELL_BITS-1 is legal.

Reset
REQ-029 RESET SHALL force IDLE, MODE=0, enables=0, BUSY=0, DONE=0, STEP_IDX=0 on the next edge, overriding any state.
REQ-030 RESET SHALL clear all table entries to zero.

Configuration
REQ-031 With FAKE_SEQ_LOOP_EN defined, LOOP=1 at last-step end SHALL return to CLEAR with STEP_IDX=0 and no DONE; ABORT is then the only exit.
REQ-032 Without FAKE_SEQ_LOOP_EN, LOOP port exists but is ignored; sequence always terminates.

Structure
REQ-033 Package fake_seq_pkg SHALL hold the state enum, CFG_DATA field bit positions and the default CLEAR_CYCLES.
REQ-034 Table storage SHALL be a sub-module fake_seq_table (NSTEPS x 32 register file, sync write, async read, sync clear).

Verification
REQ-035 Write entry0={1,0,5,10}, NUM_STEPS=1, START -> MODE=0 for 4 cycles, MODE=5/SHWR=1 for 10 cycles, 4 clear cycles, DONE pulse, BUSY low.
REQ-036 Three entries dwell 3,0,7 -> RUN lengths 3,1,7 with 4-cycle clears between; STEP_IDX 0,1,2.
REQ-037 ABORT at RUN cycle 5 of dwell 100 -> next cycle MODE=0, 4 clear cycles, DONE, STEP_IDX=0.
REQ-038 START+ABORT same cycle in IDLE -> BUSY stays 0, no DONE; CFG_WE during RUN -> entry unchanged on re-read run.
REQ-039 RESET mid-RUN -> next cycle all outputs zero, IDLE; subsequent START with NUM_STEPS=1 runs zeroed entry (MODE=0, dwell 1).
REQ-040 FAKE_SEQ_LOOP_EN, LOOP=1, 2 steps -> steps repeat 0,1,0,1 without DONE until ABORT, then DONE after clear.

Source files
------------

// File: rtl/fake_seq_pkg.sv
// Shared definitions for the fake signal sequencer.
// Holds the FSM state enum, CFG_DATA field positions and default clear length.
package fake_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int CFG_SHWR_BIT = 31;
  localparam int CFG_MUON_BIT = 30;
  localparam int CFG_MODE_HI  = 29;
  localparam int CFG_MODE_LO  = 25;
  localparam int CFG_DWELL_HI = 24;
  localparam int CFG_DWELL_LO = 0;

  localparam int DEF_CLEAR_CYCLES = 4;

endpackage

// File: rtl/fake_seq_table.sv
// Program table: NSTEPS x 32 register file, sync write, async read, sync clear.
// Ports: clk, rst (sync clear), we/waddr/wdata write port, raddr/rdata read port.
module fake_seq_table #(
  parameter int NSTEPS = 8,
  parameter int AW     = $clog2(NSTEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [NSTEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTEPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fake_signal_sequencer.sv
// Steps a fake signal generator through a programmed table of MODE/enable/dwell
// entries, holding MODE=0 for CLEAR_CYCLES before every step and after the last.
// Ports: CLK, RESET (sync, active high), START/ABORT pulses, LOOP, NUM_STEPS,
// CFG_WE/CFG_ADDR/CFG_DATA table write, MODE/USE_FAKE_SHWR/USE_FAKE_MUON drive,
// BUSY, DONE pulse, STEP_IDX.
// Build option: define FAKE_SEQ_LOOP_EN to honour LOOP (repeat until ABORT).
module fake_signal_sequencer
  import fake_seq_pkg::*;
#(
  parameter int NSTEPS       = 8,
  parameter int DWELL_BITS   = 25,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic                      ABORT,
  input  logic                      LOOP,
  input  logic [$clog2(NSTEPS):0]   NUM_STEPS,
  input  logic                      CFG_WE,
  input  logic [$clog2(NSTEPS)-1:0] CFG_ADDR,
  input  logic [31:0]               CFG_DATA,
  output logic [4:0]                MODE,
  output logic                      USE_FAKE_SHWR,
  output logic                      USE_FAKE_MUON,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [$clog2(NSTEPS)-1:0] STEP_IDX
);

  localparam int SW = $clog2(NSTEPS);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);

`ifdef FAKE_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  state_e          state;
  logic            fin;
  logic [SW:0]     nsteps_q;
  logic [SW:0]     n_clamp;
  logic [CW-1:0]   clr_cnt;
  logic [DWELL_BITS-1:0] dwell_cnt;
  logic [DWELL_BITS-1:0] dwell_v;
  logic [31:0]     entry;
  logic            tbl_we;
  logic            more;
  logic            loop_req;

  assign tbl_we   = CFG_WE && (state == ST_IDLE);
  assign n_clamp  = (NUM_STEPS > (SW+1)'(NSTEPS)) ? (SW+1)'(NSTEPS)
                                                 : NUM_STEPS;
  assign more     = (({1'b0, STEP_IDX}) + (SW+1)'(1)) < nsteps_q;
  assign loop_req = LOOP & LOOP_EN;
  assign dwell_v  = DWELL_BITS'(entry[CFG_DWELL_HI:CFG_DWELL_LO]);

  fake_seq_table #(
    .NSTEPS (NSTEPS)
  ) u_table (
    .clk   (CLK),
    .rst   (RESET),
    .we    (tbl_we),
    .waddr (CFG_ADDR),
    .wdata (CFG_DATA),
    .raddr (STEP_IDX),
    .rdata (entry)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      MODE          <= '0;
      USE_FAKE_SHWR <= 1'b0;
      USE_FAKE_MUON <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      STEP_IDX      <= '0;
      fin           <= 1'b0;
      nsteps_q      <= '0;
      clr_cnt       <= '0;
      dwell_cnt     <= '0;
    end else begin
      DONE <= 1'b0;
      if (ABORT && state != ST_IDLE) begin
        // abort restarts a full final clear from wherever we are
        state         <= ST_CLEAR;
        MODE          <= '0;
        USE_FAKE_SHWR <= 1'b0;
        USE_FAKE_MUON <= 1'b0;
        clr_cnt       <= CLR_LOAD;
        fin           <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (START && !ABORT) begin
              state    <= ST_CLEAR;
              BUSY     <= 1'b1;
              STEP_IDX <= '0;
              clr_cnt  <= CLR_LOAD;
              nsteps_q <= n_clamp;
              fin      <= (n_clamp == '0);
            end
          end
          ST_CLEAR: begin
            if (clr_cnt != '0) begin
              clr_cnt <= clr_cnt - 1'b1;
            end else if (fin) begin
              state    <= ST_IDLE;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              STEP_IDX <= '0;
              fin      <= 1'b0;
            end else begin
              state         <= ST_RUN;
              MODE          <= entry[CFG_MODE_HI:CFG_MODE_LO];
              USE_FAKE_SHWR <= entry[CFG_SHWR_BIT];
              USE_FAKE_MUON <= entry[CFG_MUON_BIT];
              // zero dwell still runs one cycle
              dwell_cnt     <= (dwell_v == '0) ? '0 : dwell_v - 1'b1;
            end
          end
          ST_RUN: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else begin
              state         <= ST_CLEAR;
              MODE          <= '0;
              USE_FAKE_SHWR <= 1'b0;
              USE_FAKE_MUON <= 1'b0;
              clr_cnt       <= CLR_LOAD;
              if (more) begin
                STEP_IDX <= STEP_IDX + 1'b1;
              end else if (loop_req) begin
                STEP_IDX <= '0;
              end else begin
                fin <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
